// File: rtl/ps2_command_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ps2_command_decoder
// Purpose  : Turns the raw PS/2 scan-code byte stream into one-cycle game
//            command pulses. Tracks break (F0) and extended (E0) prefixes,
//            suppresses typematic auto-repeat through an 11-bit held-key mask,
//            and remembers the most recently selected asset.
// Ports    : CLOCK_50          in   system clock, rising edge
//            reset             in   asynchronous, active-high
//            received_data     in   [7:0] scan-code byte
//            received_data_en  in   one-cycle byte strobe
//            click             out  Space make pulse (0x29)
//            buy               out  Enter make pulse (0x5A)
//            upgrade_click     out  U make pulse (0x3C)
//            asset_pulse       out  [7:0] one-hot pulse, bit n = key n+1
//            selected_asset    out  [2:0] last asset key pressed, held
//            selection         out  pulse alongside any asset_pulse bit
// Revision : 1.0 - initial release
// ============================================================================
module ps2_command_decoder #(
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic       click,
  output logic       buy,
  output logic       upgrade_click,
  output logic [7:0] asset_pulse,
  output logic [2:0] selected_asset,
  output logic       selection
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] c_code_break = 8'hF0;
  localparam logic [7:0] c_code_ext   = 8'hE0;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_BREAK     = 2'd1,
    S_EXT       = 2'd2,
    S_EXT_BREAK = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [10:0]      held_q, held_d;
  logic             click_q, click_d;
  logic             buy_q, buy_d;
  logic             upgrade_q, upgrade_d;
  logic [7:0]       asset_q, asset_d;
  logic [2:0]       sel_asset_q, sel_asset_d;
  logic             selection_q, selection_d;

  // Key lookup: w_idx is the held-mask bit (0 Space, 1 Enter, 2 U, 3..10
  // asset keys 1..8); w_asset is the asset number for the asset keys.
  logic       w_mapped;
  logic       w_is_asset;
  logic [3:0] w_idx;
  logic [2:0] w_asset;

  always_comb begin
    w_mapped   = 1'b1;
    w_is_asset = 1'b1;
    w_idx      = 4'd0;
    w_asset    = 3'd0;
    case (received_data)
      8'h29:   begin w_idx = 4'd0;  w_is_asset = 1'b0; end
      8'h5A:   begin w_idx = 4'd1;  w_is_asset = 1'b0; end
      8'h3C:   begin w_idx = 4'd2;  w_is_asset = 1'b0; end
      8'h16:   begin w_idx = 4'd3;  w_asset = 3'd0; end
      8'h1E:   begin w_idx = 4'd4;  w_asset = 3'd1; end
      8'h26:   begin w_idx = 4'd5;  w_asset = 3'd2; end
      8'h25:   begin w_idx = 4'd6;  w_asset = 3'd3; end
      8'h2E:   begin w_idx = 4'd7;  w_asset = 3'd4; end
      8'h36:   begin w_idx = 4'd8;  w_asset = 3'd5; end
      8'h3D:   begin w_idx = 4'd9;  w_asset = 3'd6; end
      8'h3E:   begin w_idx = 4'd10; w_asset = 3'd7; end
      default: begin w_mapped = 1'b0; w_is_asset = 1'b0; end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    held_d      = held_q;
    click_d     = 1'b0;
    buy_d       = 1'b0;
    upgrade_d   = 1'b0;
    asset_d     = 8'h00;
    selection_d = 1'b0;
    sel_asset_d = sel_asset_q;

    if (received_data_en) begin
      // A byte always wins over a coincident timeout.
      cnt_d = '0;
      case (state_q)
        S_IDLE: begin
          if (received_data == c_code_break) begin
            state_d = S_BREAK;
          end else if (received_data == c_code_ext) begin
            state_d = S_EXT;
          end else if (w_mapped && !held_q[w_idx]) begin
            // First make of a key fires; repeats while held are swallowed.
            held_d[w_idx] = 1'b1;
            if (w_is_asset) begin
              asset_d[w_asset] = 1'b1;
              selection_d      = 1'b1;
              sel_asset_d      = w_asset;
            end else begin
              click_d   = (w_idx == 4'd0);
              buy_d     = (w_idx == 4'd1);
              upgrade_d = (w_idx == 4'd2);
            end
          end
        end
        S_BREAK: begin
          if (w_mapped) begin
            held_d[w_idx] = 1'b0;
          end
          state_d = S_IDLE;
        end
        S_EXT: begin
          state_d = (received_data == c_code_break) ? S_EXT_BREAK : S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else if (state_q != S_IDLE) begin
      // An abandoned prefix drops back to IDLE; the held mask is untouched.
      if (cnt_q == c_timeout_last) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      held_q      <= '0;
      click_q     <= 1'b0;
      buy_q       <= 1'b0;
      upgrade_q   <= 1'b0;
      asset_q     <= 8'h00;
      sel_asset_q <= 3'd0;
      selection_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      held_q      <= held_d;
      click_q     <= click_d;
      buy_q       <= buy_d;
      upgrade_q   <= upgrade_d;
      asset_q     <= asset_d;
      sel_asset_q <= sel_asset_d;
      selection_q <= selection_d;
    end
  end

  assign click          = click_q;
  assign buy            = buy_q;
  assign upgrade_click  = upgrade_q;
  assign asset_pulse    = asset_q;
  assign selected_asset = sel_asset_q;
  assign selection      = selection_q;

endmodule
`default_nettype wire

// File: doc/ps2_command_decoder.md
# ps2_command_decoder

Converts the raw PS/2 byte stream from the keyboard controller into one-cycle game command pulses for the logic controller/datapath. Sits directly downstream of the PS/2 controller (`received_data`, `received_data_en`) and upstream of the click/buy/upgrade/asset-select logic. Handles break (F0) and extended (E0) prefixes, and suppresses typematic auto-repeat so that one physical press yields exactly one command. Also holds the currently selected asset.

## Interface
- `TIMEOUT_CYCLES`, default 5_000_000: idle cycles after a prefix byte before the decoder abandons the sequence (100 ms at 50 MHz).
- `CLOCK_50`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `received_data`  in  8  scan-code byte from the PS/2 controller, valid when `received_data_en` = 1.
- `received_data_en`  in  1  one-cycle strobe per received byte; may assert on consecutive cycles.
- `click`  out  1  one-cycle pulse on Space make (0x29).
- `buy`  out  1  one-cycle pulse on Enter make (0x5A).
- `upgrade_click`  out  1  one-cycle pulse on U make (0x3C).
- `asset_pulse`  out  8  one-hot one-cycle pulse; bit n = key n+1 make. Codes 1..8 = 0x16, 0x1E, 0x26, 0x25, 0x2E, 0x36, 0x3D, 0x3E.
- `selected_asset`  out  3  index of the last asset key pressed (0 = key 1), held.
- `selection`  out  1  one-cycle pulse coincident with any `asset_pulse` bit.

## Operation
- Prefix FSM, states IDLE, BREAK, EXT, EXT_BREAK; reset state is IDLE.
- IDLE: byte F0 -> BREAK; E0 -> EXT; any other byte is a make code, decoded, stay IDLE.
- BREAK: any byte is a break code: clear that key's held bit if mapped; -> IDLE. No pulse.
- EXT: F0 -> EXT_BREAK; any other byte is discarded; -> IDLE.
- EXT_BREAK: any byte is discarded; -> IDLE. All extended keys, including keypad Enter (E0 5A), are ignored.
- Held mask, 11 bits: Space, Enter, U, and 1..8.
  - Make of a mapped key with its held bit 0: set the held bit and fire the command pulse.
  - Make with the held bit already 1 (typematic repeat): no pulse.
  - Unmapped make codes are ignored with no state change.
- Asset make that fires: `asset_pulse[n]` = 1, `selection` = 1, and `selected_asset` <= n in the same clock edge.
- Prefix timeout: a counter clears on every `received_data_en` and counts while in any state other than IDLE. When it reaches TIMEOUT_CYCLES-1 the FSM returns to IDLE. The held mask is unchanged.
- Prefix bytes F0/E0 received while already in BREAK/EXT/EXT_BREAK are consumed as the payload byte (no nesting).

## Timing
- All outputs are registered. A pulse is high exactly one cycle, the cycle after the edge that sampled the final byte's `received_data_en`. Latency is 1 cycle.
- At most one command pulse per cycle, since one byte is processed per cycle. Back-to-back strobes are each processed with no loss.
- `received_data_en` and timeout in the same cycle: the byte is processed, the timeout is ignored, and the counter clears.
- Reset values: `click`, `buy`, `upgrade_click`, `selection` = 0; `asset_pulse` = 8'h00; `selected_asset` = 3'd0; FSM = IDLE; held mask = 0; timeout counter = 0.
- Reset asserted mid-sequence (e.g. after F0): outputs clear immediately. The next byte after release is treated as a make code.
- `received_data` is ignored whenever `received_data_en` = 0.

## Test plan
- Make/break: after reset send 0x29, then F0 29. Expect `click` high exactly 1 cycle after the first strobe and no other pulses. Held mask returns to 0.
- Typematic: send 0x5A, 0x5A, 0x5A, then F0 5A, then 0x5A. Expect exactly two `buy` pulses (first and last make).
- Asset select: send 0x26, then 0x3E. Expect `asset_pulse` = 8'h04 with `selection` = 1 and `selected_asset` = 2, then 8'h80 with `selected_asset` = 7, which holds afterwards.
- Extended: send E0 5A and E0 F0 5A, then 0x3C. Expect no `buy` pulse, a single `upgrade_click` pulse, and FSM = IDLE at end.
- Timeout with TIMEOUT_CYCLES = 16: send F0, wait 20 cycles, send 0x16. Expect `asset_pulse` = 8'h01. Repeat with a 10-cycle wait: expect no pulse (0x16 is treated as a break).
- Async reset: send F0, assert `reset` mid-cycle for 3 cycles, release, send 0x29. Expect outputs 0 during reset and a `click` pulse after release.
